// File: rtl/tick_stepper.sv
// rtl/tick_stepper.sv - single-clock prescaled / single-step counter feeding the one-hot display stage
//
// Counts on one clock (CLK): either free-runs, advancing once every TICK_DIV cycles,
// or advances one step per button press. num_valid_o marks the first cycle
// num_o shows each new value.
//
// Parameters:
//   TICK_DIV     prescaler period in CLK cycles (>= 2)
//   COUNT_WIDTH  width of num_o
//   DEB_CYCLES   debounce stability window in CLK cycles (STEP_DEBOUNCE_EN builds only)
//
// Ports:
//   CLK          system clock, sole clock
//   RST_N        asynchronous active-low reset
//   run_i        level: 1 = free-run, 0 = pause
//   dir_i        0 = count up, 1 = count down
//   clear_i      zero the count and prescaler (highest priority below reset)
//   step_i       raw asynchronous button, active-high
//   num_o        current value
//   num_valid_o  one-cycle strobe when num_o changes or is cleared
//   tick_o       one-cycle pulse on each prescaler wrap while running
//
// Build option: define STEP_DEBOUNCE_EN to insert a debouncer between the
// step synchroniser and the edge detector.

module tick_stepper #(
    parameter int TICK_DIV    = 4194304,
    parameter int COUNT_WIDTH = 2,
    parameter int DEB_CYCLES  = 160000
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   run_i,
    input  logic                   dir_i,
    input  logic                   clear_i,
    input  logic                   step_i,
    output logic [COUNT_WIDTH-1:0] num_o,
    output logic                   num_valid_o,
    output logic                   tick_o
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_PAUSE = 2'd0,
        S_STEP  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   presc, presc_n;
    logic            do_update;
    logic            do_tick;

    logic            step_sync1;
    logic            step_sync2;
    logic            step_level;
    logic            step_prev;
    logic            step_edge;

    // Button synchroniser
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            step_sync1 <= 1'b0;
            step_sync2 <= 1'b0;
        end else begin
            step_sync1 <= step_i;
            step_sync2 <= step_sync1;
        end
    end

`ifdef STEP_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [DW-1:0] deb_cnt;
    logic          deb_level;

    // The level follows sync2 only once the new value has been seen on
    // DEB_CYCLES consecutive edges; any return to the old value restarts.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (step_sync2 != deb_level) begin
            if (deb_cnt == DEB_LAST) begin
                deb_level <= step_sync2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign step_level = deb_level;
`else
    assign step_level = step_sync2;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            step_prev <= 1'b0;
        end else begin
            step_prev <= step_level;
        end
    end

    assign step_edge = step_level & ~step_prev;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_PAUSE;
            presc <= '0;
        end else begin
            state <= state_n;
            presc <= presc_n;
        end
    end

    always_comb begin
        state_n   = state;
        presc_n   = presc;
        do_update = 1'b0;
        do_tick   = 1'b0;

        case (state)
            S_PAUSE: begin
                presc_n = '0;
                if (run_i) begin
                    state_n = S_RUN;
                end else if (step_edge) begin
                    state_n = S_STEP;
                end
            end
            S_STEP: begin
                presc_n   = '0;
                do_update = 1'b1;
                state_n   = run_i ? S_RUN : S_PAUSE;
            end
            S_RUN: begin
                if (!run_i) begin
                    // Leaving RUN abandons the partial prescale period.
                    state_n = S_PAUSE;
                    presc_n = '0;
                end else if (presc == PRESC_LAST) begin
                    presc_n   = '0;
                    do_update = 1'b1;
                    do_tick   = 1'b1;
                end else begin
                    presc_n = presc + 1'b1;
                end
            end
            default: begin
                state_n = S_PAUSE;
                presc_n = '0;
            end
        endcase

        // Clear swallows any tick or step landing in the same cycle but
        // leaves the state transition alone.
        if (clear_i) begin
            presc_n   = '0;
            do_update = 1'b0;
            do_tick   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            num_o       <= '0;
            num_valid_o <= 1'b0;
            tick_o      <= 1'b0;
        end else begin
            if (clear_i) begin
                num_o <= '0;
            end else if (do_update) begin
                num_o <= dir_i ? num_o - 1'b1 : num_o + 1'b1;
            end
            num_valid_o <= clear_i | do_update;
            tick_o      <= do_tick;
        end
    end

endmodule

// File: tb/tb_tick_stepper.sv
// tb/tb_tick_stepper.sv - scoreboard testbench for tick_stepper

module tb_tick_stepper;

    localparam int TICK_DIV    = 8;
    localparam int COUNT_WIDTH = 2;
    localparam int DEB_CYCLES  = 4;

    logic                   CLK;
    logic                   RST_N;
    logic                   run_i;
    logic                   dir_i;
    logic                   clear_i;
    logic                   step_i;
    logic [COUNT_WIDTH-1:0] num_o;
    logic                   num_valid_o;
    logic                   tick_o;

    int checks = 0;
    int errors = 0;
    logic [COUNT_WIDTH-1:0] exp_q[$];

    tick_stepper #(
        .TICK_DIV    (TICK_DIV),
        .COUNT_WIDTH (COUNT_WIDTH),
        .DEB_CYCLES  (DEB_CYCLES)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .run_i       (run_i),
        .dir_i       (dir_i),
        .clear_i     (clear_i),
        .step_i      (step_i),
        .num_o       (num_o),
        .num_valid_o (num_valid_o),
        .tick_o      (tick_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard: every valid strobe consumes one expected value.
    always @(negedge CLK) begin
        logic [COUNT_WIDTH-1:0] e;
        if (RST_N && num_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_valid: num_o=%0d with no expected value queued", num_o);
            end else begin
                e = exp_q.pop_front();
                if (num_o !== e) begin
                    errors++;
                    $display("FAIL sb_value: num_o=%0d expected %0d", num_o, e);
                end
            end
        end
    end

    task automatic test_reset();
        RST_N   = 1'b0;
        run_i   = 1'b0;
        dir_i   = 1'b0;
        clear_i = 1'b0;
        step_i  = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            checks++;
            if (num_o !== '0 || num_valid_o !== 1'b0 || tick_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle c=%0d: num=%0d valid=%b tick=%b expected 0/0/0",
                         c, num_o, num_valid_o, tick_o);
            end
        end
    endtask

    task automatic test_free_run_up();
        logic exp_p;
        @(posedge CLK);
        #1;
        dir_i = 1'b0;
        run_i = 1'b1;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        @(posedge CLK);
        for (int c = 0; c <= 35; c++) begin
            @(negedge CLK);
            exp_p = (c > 0) && (c % TICK_DIV == 0);
            checks++;
            if (num_valid_o !== exp_p || tick_o !== exp_p) begin
                errors++;
                $display("FAIL free_run_pulse c=%0d: valid=%b tick=%b expected %b",
                         c, num_valid_o, tick_o, exp_p);
            end
        end
        @(posedge CLK);
        #1 run_i = 1'b0;
        repeat (12) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL free_run_drain: %0d updates missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_step_down();
        logic exp_p;
        for (int p = 0; p < 2; p++) begin
            @(posedge CLK);
            #1;
            dir_i  = 1'b1;
            step_i = 1'b1;
            exp_q.push_back(p == 0 ? 2'd3 : 2'd2);
            @(posedge CLK);
            for (int c = 0; c <= 12; c++) begin
                @(negedge CLK);
                if (c == 4) step_i = 1'b0;
                exp_p = (c == 3);
                checks++;
                if (num_valid_o !== exp_p || tick_o !== 1'b0) begin
                    errors++;
                    $display("FAIL step_down p=%0d c=%0d: valid=%b tick=%b expected %b/0",
                             p, c, num_valid_o, tick_o, exp_p);
                end
            end
        end
        checks++;
        if (num_o !== 2'd2) begin
            errors++;
            $display("FAIL step_down_final: num=%0d expected 2", num_o);
        end
    endtask

    task automatic test_clear_collision();
        logic exp_v;
        logic exp_t;
        @(posedge CLK);
        #1;
        dir_i = 1'b0;
        run_i = 1'b1;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        @(posedge CLK);
        for (int c = 0; c <= 18; c++) begin
            @(negedge CLK);
            if (c == 7) clear_i = 1'b1;
            if (c == 8) clear_i = 1'b0;
            exp_v = (c == 8) || (c == 16);
            exp_t = (c == 16);
            checks++;
            if (num_valid_o !== exp_v || tick_o !== exp_t) begin
                errors++;
                $display("FAIL clear_collision c=%0d: valid=%b tick=%b expected %b/%b",
                         c, num_valid_o, tick_o, exp_v, exp_t);
            end
        end
        @(posedge CLK);
        #1 run_i = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_mid_reset();
        @(posedge CLK);
        #1 run_i = 1'b1;
        @(posedge CLK);
        repeat (5) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        run_i = 1'b0;
        #1;
        checks++;
        if (num_o !== '0 || num_valid_o !== 1'b0 || tick_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: num=%0d valid=%b tick=%b expected 0/0/0",
                     num_o, num_valid_o, tick_o);
        end
        @(posedge CLK);
        #1 RST_N = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            checks++;
            if (num_o !== '0 || num_valid_o !== 1'b0 || tick_o !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_idle c=%0d: num=%0d valid=%b tick=%b expected 0/0/0",
                         c, num_o, num_valid_o, tick_o);
            end
        end
    endtask

    task automatic test_free_run_down_wrap();
        logic exp_p;
        @(posedge CLK);
        #1;
        dir_i = 1'b1;
        run_i = 1'b1;
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd2);
        @(posedge CLK);
        for (int c = 0; c <= 17; c++) begin
            @(negedge CLK);
            exp_p = (c == 8) || (c == 16);
            checks++;
            if (num_valid_o !== exp_p || tick_o !== exp_p) begin
                errors++;
                $display("FAIL down_wrap c=%0d: valid=%b tick=%b expected %b",
                         c, num_valid_o, tick_o, exp_p);
            end
        end
        @(posedge CLK);
        #1 run_i = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (num_o !== 2'd2) begin
            errors++;
            $display("FAIL down_wrap_final: num=%0d expected 2", num_o);
        end
    endtask

`ifdef STEP_DEBOUNCE_EN
    task automatic test_debounce();
        logic exp_p;
        @(posedge CLK);
        #1;
        dir_i  = 1'b1;
        step_i = 1'b1;
        @(posedge CLK);
        for (int c = 0; c <= 15; c++) begin
            @(negedge CLK);
            if (c == 1) step_i = 1'b0;
            checks++;
            if (num_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL debounce_glitch c=%0d: valid=%b expected 0", c, num_valid_o);
            end
        end
        @(posedge CLK);
        #1 step_i = 1'b1;
        exp_q.push_back(2'd1);
        @(posedge CLK);
        for (int c = 0; c <= 14; c++) begin
            @(negedge CLK);
            if (c == 5) step_i = 1'b0;
            exp_p = (c == 3 + DEB_CYCLES);
            checks++;
            if (num_valid_o !== exp_p) begin
                errors++;
                $display("FAIL debounce_press c=%0d: valid=%b expected %b", c, num_valid_o, exp_p);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run_up();
        test_step_down();
        test_clear_collision();
        test_mid_reset();
        test_free_run_down_wrap();
`ifdef STEP_DEBOUNCE_EN
        test_debounce();
`endif
        repeat (4) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: %0d expected updates never seen", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_stepper.md
Name: tick_stepper

Overview:
Upstream value source for the one-hot LED/PIN_1..PIN_3 display stage.
- Replaces the derived-clock counter (posedge of a counter bit) with a single-clock design on CLK.
- Produces a COUNT_WIDTH-bit value that free-runs at a prescaled rate or advances one step per button press.
- Raises a one-cycle valid strobe whenever the value changes.

Parameters:
TICK_DIV, 4194304, prescaler period in CLK cycles (about 3.8 Hz at 16 MHz); legal range >= 2.
COUNT_WIDTH, 2, width of num_o.
DEB_CYCLES, 160000, debounce stability window in CLK cycles (10 ms at 16 MHz); used only with STEP_DEBOUNCE_EN.

Ports:
CLK  input  1  16 MHz system clock; sole clock.
RST_N  input  1  reset, asynchronous assert, active-low.
run_i  input  1  synchronous level: 1 = free-run, 0 = pause.
dir_i  input  1  synchronous: 0 = count up, 1 = count down.
clear_i  input  1  synchronous: zero the count.
step_i  input  1  raw asynchronous button input, active-high.
num_o  output  COUNT_WIDTH  current value.
num_valid_o  output  1  high for exactly the first cycle num_o shows a new value.
tick_o  output  1  one-cycle pulse on each prescaler wrap while in RUN.

Behaviour:
- Reset (RST_N low, takes effect immediately): all outputs and internal state cleared.
  - num_o = 0, num_valid_o = 0, tick_o = 0.
  - Prescaler = 0, state = PAUSE, step synchroniser and edge-detect flops = 0.
- step_i path:
  - Two-flop synchroniser, then one registered "previous" flop.
  - step_edge = sync2 & ~prev.
- State machine, evaluated each CLK edge:
  - PAUSE: if run_i, go to RUN. Else if step_edge, go to STEP. Prescaler held at 0.
  - STEP: lasts one cycle. Apply one update, then return to PAUSE. If run_i is high in this cycle, go to RUN instead (update still applied).
  - RUN: prescaler increments and wraps at TICK_DIV-1 back to 0.
    - At the wrap edge, tick_o = 1 and apply one update.
    - If run_i is low, go to PAUSE and zero the prescaler; no update occurs in that cycle.
    - step_edge is ignored in RUN.
- Update rule:
  - num_o <= num_o + 1 (dir_i = 0) or num_o - 1 (dir_i = 1), modulo 2^COUNT_WIDTH.
  - Wrap-around: max -> 0 when counting up, 0 -> max when counting down.
  - num_valid_o = 1 in the same cycle num_o first shows the new value, 0 otherwise.
- clear_i has highest priority below reset:
  - num_o <= 0 and prescaler <= 0; state is unchanged.
  - num_valid_o pulses 1 even if num_o was already 0.
  - A tick or step landing in the same cycle is discarded; tick_o stays 0.
- Timing:
  - RUN: run_i sampled high at edge e gives the first update at edge e+TICK_DIV, then one update every TICK_DIV cycles.
  - Step: step_i first sampled high at edge k gives num_o updated at edge k+3.
- Mid-operation: an asynchronous reset during STEP or mid-prescale discards the pending update.
- No back-pressure: the downstream stage must accept num_valid_o in any cycle.

Optional Feature:
STEP_DEBOUNCE_EN
- Defined: a debouncer sits between sync2 and the edge detector.
  - The debounced level changes only after sync2 holds a new value for DEB_CYCLES consecutive cycles; a mismatch restarts the count.
  - Step latency becomes k+3+DEB_CYCLES.
  - Debounced level and its counter reset to 0.
- Undefined: no debouncer; latency is k+3; the DEB_CYCLES parameter is unused.

Test Plan:
1. Reset behaviour: TICK_DIV=8, RST_N low then released, run_i=0 -> num_o=0, num_valid_o=0, tick_o=0 for 50 cycles.
2. Free-run wrap: run_i=1 at edge e, dir_i=0 -> num_o = 1,2,3,0 at edges e+8, e+16, e+24, e+32; tick_o and num_valid_o each pulse one cycle at those edges.
3. Single step, count down: run_i=0, dir_i=1, step_i high from edge k for 5 cycles -> num_o goes 0->3 at edge k+3, exactly one num_valid_o pulse; a second press gives 2.
4. Clear collision: TICK_DIV=8, clear_i asserted on the wrap cycle with num_o=2 -> num_o=0, tick_o=0, num_valid_o=1; the next update arrives 8 cycles later.
5. Mid-operation reset: RST_N low for 1 cycle during RUN at prescaler=5 -> outputs clear immediately; state PAUSE after release; no update fires.
6. Debounce (STEP_DEBOUNCE_EN, DEB_CYCLES=4): step_i glitches high 2 cycles then low -> no update; held high 6 cycles -> one update at k+7.
